// File: rtl/usb1_token_rx.sv
`default_nettype none
// ============================================================================
// Module      : usb1_token_rx
// Description : USB 1.x token packet receiver on the UTMI receive byte
//               stream. Checks the PID check nibble, collects the two token
//               bytes, runs CRC5 over them and reports a good token, a CRC
//               failure, a bad PID or a wrong byte count as one-cycle pulses.
//               Token fields and the SOF frame number are held until the next
//               good token.
// Revision    : 1.0 - initial release
// ============================================================================
module usb1_token_rx (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_active,
    input  logic        rx_err,
    output logic        token_valid,
    output logic [3:0]  token_pid,
    output logic [6:0]  token_addr,
    output logic [3:0]  token_endp,
    output logic [10:0] frame_no,
    output logic        crc5_err,
    output logic        pid_err,
    output logic        seq_err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_PID  = 3'd1;
    localparam logic [2:0] c_ST_B1   = 3'd2;
    localparam logic [2:0] c_ST_B2   = 3'd3;
    localparam logic [2:0] c_ST_END  = 3'd4;
    localparam logic [2:0] c_ST_DROP = 3'd5;

    // ------------------------------------------------------------------------
    // CRC5 constants: x^5 + x^2 + 1, preset to all ones; a token whose CRC
    // field is correct leaves the fixed residual below in the register.
    // ------------------------------------------------------------------------
    localparam logic [4:0] c_CRC_INIT  = 5'b11111;
    localparam logic [4:0] c_CRC_POLY  = 5'b00101;
    localparam logic [4:0] c_CRC_RESID = 5'b01100;

    // Token PIDs (low nibble of the PID byte)
    localparam logic [3:0] c_PID_OUT   = 4'b0001;
    localparam logic [3:0] c_PID_IN    = 4'b1001;
    localparam logic [3:0] c_PID_SOF   = 4'b0101;
    localparam logic [3:0] c_PID_SETUP = 4'b1101;

    // ------------------------------------------------------------------------
    // Eight serial CRC5 steps over one byte, LSB (first bit on the wire)
    // first. Unrolled by synthesis into a single-cycle XOR network.
    // ------------------------------------------------------------------------
    function automatic logic [4:0] crc5_byte(input logic [4:0] crc_in,
                                             input logic [7:0] data);
        logic [4:0] crc;
        logic       fb;
        crc = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb  = crc[4] ^ data[i];
            crc = {crc[3:0], 1'b0} ^ (fb ? c_CRC_POLY : 5'b00000);
        end
        return crc;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [4:0]  r_crc;
    logic [3:0]  r_pid;       // PID of the packet in progress
    logic [7:0]  r_byte1;     // first token byte
    logic [2:0]  r_byte2_lo;  // low bits of the second token byte (rest is CRC)

    logic        r_token_valid;
    logic [3:0]  r_token_pid;
    logic [6:0]  r_token_addr;
    logic [3:0]  r_token_endp;
    logic [10:0] r_frame_no;
    logic        r_crc5_err;
    logic        r_pid_err;
    logic        r_seq_err;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [4:0] w_crc_next;
    logic       w_pid_check_ok;
    logic       w_pid_is_token;
    logic       w_crc_good;

    assign w_crc_next     = crc5_byte(r_crc, rx_data);
    assign w_pid_check_ok = (rx_data[7:4] == ~rx_data[3:0]);
    assign w_pid_is_token = (rx_data[3:0] == c_PID_OUT)   ||
                            (rx_data[3:0] == c_PID_IN)    ||
                            (rx_data[3:0] == c_PID_SOF)   ||
                            (rx_data[3:0] == c_PID_SETUP);
    assign w_crc_good     = (r_crc == c_CRC_RESID);

    // ------------------------------------------------------------------------
    // Packet FSM with registered result pulses and held token fields.
    // Pulses default low every cycle so each lasts exactly one cycle, and
    // every pulse is issued from a distinct transition so at most one fires.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_ST_IDLE;
            r_crc         <= c_CRC_INIT;
            r_pid         <= 4'd0;
            r_byte1       <= 8'd0;
            r_byte2_lo    <= 3'd0;
            r_token_valid <= 1'b0;
            r_token_pid   <= 4'd0;
            r_token_addr  <= 7'd0;
            r_token_endp  <= 4'd0;
            r_frame_no    <= 11'd0;
            r_crc5_err    <= 1'b0;
            r_pid_err     <= 1'b0;
            r_seq_err     <= 1'b0;
        end else begin
            r_token_valid <= 1'b0;
            r_crc5_err    <= 1'b0;
            r_pid_err     <= 1'b0;
            r_seq_err     <= 1'b0;

            if ((r_state != c_ST_IDLE) && rx_err) begin
                // A receive error poisons the whole packet, silently.
                r_state <= c_ST_DROP;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        // Re-preset the CRC so every packet starts clean.
                        r_crc <= c_CRC_INIT;
                        if (rx_active) begin
                            r_state <= c_ST_PID;
                        end
                    end

                    c_ST_PID: begin
                        if (!rx_active) begin
                            // Packet ended before any byte: nothing to report.
                            r_state <= c_ST_IDLE;
                        end else if (rx_valid) begin
                            if (!w_pid_check_ok) begin
                                r_pid_err <= 1'b1;
                                r_state   <= c_ST_DROP;
                            end else if (!w_pid_is_token) begin
                                // Data/handshake packets are not ours.
                                r_state <= c_ST_DROP;
                            end else begin
                                r_pid   <= rx_data[3:0];
                                r_state <= c_ST_B1;
                            end
                        end
                    end

                    c_ST_B1: begin
                        if (!rx_active) begin
                            r_seq_err <= 1'b1;
                            r_state   <= c_ST_IDLE;
                        end else if (rx_valid) begin
                            r_byte1 <= rx_data;
                            r_crc   <= w_crc_next;
                            r_state <= c_ST_B2;
                        end
                    end

                    c_ST_B2: begin
                        if (!rx_active) begin
                            r_seq_err <= 1'b1;
                            r_state   <= c_ST_IDLE;
                        end else if (rx_valid) begin
                            r_byte2_lo <= rx_data[2:0];
                            r_crc      <= w_crc_next;
                            r_state    <= c_ST_END;
                        end
                    end

                    c_ST_END: begin
                        if (!rx_active) begin
                            r_state <= c_ST_IDLE;
                            if (w_crc_good) begin
                                r_token_valid <= 1'b1;
                                r_token_pid   <= r_pid;
                                r_token_addr  <= r_byte1[6:0];
                                r_token_endp  <= {r_byte2_lo, r_byte1[7]};
                                if (r_pid == c_PID_SOF) begin
                                    r_frame_no <= {r_byte2_lo, r_byte1};
                                end
                            end else begin
                                r_crc5_err <= 1'b1;
                            end
                        end else if (rx_valid) begin
                            // A token is exactly three bytes long.
                            r_seq_err <= 1'b1;
                            r_state   <= c_ST_DROP;
                        end
                    end

                    c_ST_DROP: begin
                        if (!rx_active) begin
                            r_state <= c_ST_IDLE;
                        end
                    end

                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign token_valid = r_token_valid;
    assign token_pid   = r_token_pid;
    assign token_addr  = r_token_addr;
    assign token_endp  = r_token_endp;
    assign frame_no    = r_frame_no;
    assign crc5_err    = r_crc5_err;
    assign pid_err     = r_pid_err;
    assign seq_err     = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_usb1_token_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb1_token_rx
// Description : Self-checking bench for usb1_token_rx. Expected output
//               vectors are queued as packets are driven and popped by a
//               monitor whenever the DUT raises a result pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb1_token_rx;

    localparam int c_CLK_HALF = 5;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_active;
    logic        rx_err;
    logic        token_valid;
    logic [3:0]  token_pid;
    logic [6:0]  token_addr;
    logic [3:0]  token_endp;
    logic [10:0] frame_no;
    logic        crc5_err;
    logic        pid_err;
    logic        seq_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Output vector: {tv, crc, pid, seq, pid[3:0], addr[6:0], endp[3:0], frame[10:0]}
    logic [31:0] sb_q[$];

    // Model of the held fields
    logic [3:0]  m_pid;
    logic [6:0]  m_addr;
    logic [3:0]  m_endp;
    logic [10:0] m_frame;

    usb1_token_rx dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_active   (rx_active),
        .rx_err      (rx_err),
        .token_valid (token_valid),
        .token_pid   (token_pid),
        .token_addr  (token_addr),
        .token_endp  (token_endp),
        .frame_no    (frame_no),
        .crc5_err    (crc5_err),
        .pid_err     (pid_err),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #c_CLK_HALF clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {2'b00, token_valid, crc5_err, pid_err, seq_err,
                token_pid, token_addr, token_endp, frame_no};
    endfunction

    function automatic logic [31:0] mk_vec(input logic [3:0] pulses);
        return {2'b00, pulses, m_pid, m_addr, m_endp, m_frame};
    endfunction

    // Serial CRC5 residual over byte1 then byte2, LSB first
    function automatic logic [4:0] residual(input logic [7:0] b1, input logic [7:0] b2);
        logic [15:0] d;
        logic [4:0]  c;
        logic        fb;
        d = {b2, b1};
        c = 5'b11111;
        for (int i = 0; i < 16; i++) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        return c;
    endfunction

    // Monitor: every pulse cycle must match the next queued expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && (token_valid | crc5_err | pid_err | seq_err)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", out_vec(), 32'h0);
            end else begin
                check("sb_pulse", out_vec(), sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected outcome of a complete three-byte packet
    task automatic expect_pkt(input logic [7:0] p, input logic [7:0] b1, input logic [7:0] b2);
        if (p[7:4] != ~p[3:0]) begin
            sb_q.push_back(mk_vec(4'b0010));
        end else if (!(p[3:0] == 4'b0001 || p[3:0] == 4'b1001 ||
                       p[3:0] == 4'b0101 || p[3:0] == 4'b1101)) begin
            // not a token: no pulse
        end else if (residual(b1, b2) == 5'b01100) begin
            m_pid  = p[3:0];
            m_addr = b1[6:0];
            m_endp = {b2[2:0], b1[7]};
            if (p[3:0] == 4'b0101) m_frame = {b2[2:0], b1};
            sb_q.push_back(mk_vec(4'b1000));
        end else begin
            sb_q.push_back(mk_vec(4'b0100));
        end
    endtask

    // Drive one packet: SYNC cycle, then n bytes each followed by a gap cycle
    task automatic send_pkt(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input int err_idx, input int gap);
        logic [7:0] bytes [4];
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        rx_active = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            rx_data  = bytes[i];
            rx_valid = 1'b1;
            rx_err   = (i == err_idx);
            tick();
            rx_valid = 1'b0;
            rx_err   = 1'b0;
            tick();
        end
        rx_active = 1'b0;
        repeat (gap) tick();
    endtask

    // Let pending pulses arrive, then require the scoreboard to be empty
    task automatic drain(input string tag);
        repeat (4) tick();
        check(tag, sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Second token byte whose CRC field makes a good token
    task automatic make_good(input logic [7:0] b1, input logic [2:0] lo, output logic [7:0] b2);
        logic found;
        found = 1'b0;
        b2 = {5'd0, lo};
        for (int c = 0; c < 32; c++) begin
            if (!found && residual(b1, {c[4:0], lo}) == 5'b01100) begin
                b2    = {c[4:0], lo};
                found = 1'b1;
            end
        end
        check("crc_gen", {31'd0, found}, 32'd1);
    endtask

    initial begin
        logic [7:0] p, b1, b2;
        logic [3:0] pid;
        int         idx;

        rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_active = 1'b0; rx_err = 1'b0;
        m_pid = '0; m_addr = '0; m_endp = '0; m_frame = '0;
        repeat (3) tick();
        check("reset_outputs", out_vec(), 32'h0);
        rst = 1'b1;
        repeat (2) tick();
        check("idle_outputs", out_vec(), 32'h0);

        // SETUP addr 0 endp 0
        expect_pkt(8'h2D, 8'h00, 8'h10);
        send_pkt(3, 8'h2D, 8'h00, 8'h10, 8'h00, -1, 1);
        drain("drain_setup");

        // SOF frame 0, then a corrupted SETUP
        expect_pkt(8'hA5, 8'h00, 8'h10);
        send_pkt(3, 8'hA5, 8'h00, 8'h10, 8'h00, -1, 1);
        drain("drain_sof");
        expect_pkt(8'h2D, 8'h00, 8'h11);
        send_pkt(3, 8'h2D, 8'h00, 8'h11, 8'h00, -1, 1);
        drain("drain_crc_bad");

        // Bad PID check nibble, then a DATA0 packet
        expect_pkt(8'h2C, 8'h00, 8'h10);
        send_pkt(3, 8'h2C, 8'h00, 8'h10, 8'h00, -1, 1);
        drain("drain_pid_bad");
        send_pkt(4, 8'hC3, 8'h11, 8'h22, 8'h33, -1, 1);
        drain("drain_data0");

        // Short and long tokens
        sb_q.push_back(mk_vec(4'b0001));
        send_pkt(2, 8'h2D, 8'h00, 8'h00, 8'h00, -1, 1);
        drain("drain_short");
        sb_q.push_back(mk_vec(4'b0001));
        send_pkt(4, 8'h2D, 8'h00, 8'h10, 8'h00, -1, 1);
        drain("drain_long");

        // rx_err on byte1: silent drop
        send_pkt(3, 8'h2D, 8'h00, 8'h10, 8'h00, 1, 1);
        drain("drain_rx_err");

        // Random tokens, some corrupted, with short inter-packet gaps
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 3))
                0: pid = 4'b0001;
                1: pid = 4'b1001;
                2: pid = 4'b0101;
                default: pid = 4'b1101;
            endcase
            p  = {~pid, pid};
            b1 = 8'($urandom);
            make_good(b1, 3'($urandom_range(0, 7)), b2);
            if (k % 3 == 2) begin
                idx = $urandom_range(0, 15);
                if (idx < 8) b1 = b1 ^ (8'd1 << idx);
                else         b2 = b2 ^ (8'd1 << (idx - 8));
            end
            expect_pkt(p, b1, b2);
            send_pkt(3, p, b1, b2, 8'h00, -1, (k % 2 == 0) ? 1 : 3);
        end
        drain("drain_random");

        // Back-to-back with a single idle cycle: a known non-zero IN token first
        b1 = {1'b1, 7'h55};
        make_good(b1, 3'd1, b2);
        expect_pkt(8'h69, b1, b2);
        send_pkt(3, 8'h69, b1, b2, 8'h00, -1, 1);
        expect_pkt(8'h2D, 8'h00, 8'h10);
        send_pkt(3, 8'h2D, 8'h00, 8'h10, 8'h00, -1, 1);
        b1 = {1'b0, 7'h2A};
        make_good(b1, 3'd6, b2);
        expect_pkt(8'hE1, b1, b2);
        send_pkt(3, 8'hE1, b1, b2, 8'h00, -1, 1);
        drain("drain_b2b");
        check("held_fields", out_vec(), mk_vec(4'b0000));

        // Reset asserted while in B2 clears outputs asynchronously
        rx_active = 1'b1; tick();
        rx_data = 8'h2D; rx_valid = 1'b1; tick(); rx_valid = 1'b0; tick();
        rx_data = 8'h00; rx_valid = 1'b1; tick(); rx_valid = 1'b0; tick();
        #2 rst = 1'b0;
        #1 check("rst_async", out_vec(), 32'h0);
        m_pid = '0; m_addr = '0; m_endp = '0; m_frame = '0;
        rx_active = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        expect_pkt(8'h2D, 8'h00, 8'h10);
        send_pkt(3, 8'h2D, 8'h00, 8'h10, 8'h00, -1, 1);
        drain("drain_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
